// File: rtl/pmp_arbiter_pkg.sv
// Shared PMP definitions: privilege levels, PMP address-matching modes,
// one-hot access types and requester identifiers.
package pmp_arbiter_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } privilege_e;

    // pmpcfg.A field encodings
    localparam logic [1:0] PMP_MODE_OFF   = 2'b00;
    localparam logic [1:0] PMP_MODE_TOR   = 2'b01;
    localparam logic [1:0] PMP_MODE_NA4   = 2'b10;
    localparam logic [1:0] PMP_MODE_NAPOT = 2'b11;

    // One-hot access type, bit order {X, W, R} matches pmpcfg[2:0]
    localparam logic [2:0] ACS_R = 3'b001;
    localparam logic [2:0] ACS_W = 3'b010;
    localparam logic [2:0] ACS_X = 3'b100;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_LSU = 1'b1
    } pmp_req_e;

endpackage

// File: rtl/pmp_arbiter_pmp.sv
// PMP checker: matches one access against all PMP entries (lowest index
// wins) and flags an access fault.
// Ports:
//   pmp_cfg        per-entry config {L, -, -, A[1:0], X, W, R}
//   pmp_addr       per-entry address (physical address bits [35:2])
//   acs_en         access present; pmp_err is 0 when low
//   acs_addr       32-bit byte address of the access
//   acs_type       one-hot {X, W, R}
//   privilege_mode privilege of the access
//   pmp_err        access fault
module pmp_arbiter_pmp
    import pmp_arbiter_pkg::*;
#(
    parameter int PMP_ENTRY = 16
) (
    input  logic [PMP_ENTRY-1:0][7:0]  pmp_cfg,
    input  logic [PMP_ENTRY-1:0][33:0] pmp_addr,
    input  logic                       acs_en,
    input  logic [31:0]                acs_addr,
    input  logic [2:0]                 acs_type,
    input  privilege_e                 privilege_mode,
    output logic                       pmp_err
);

    logic [33:0]                word;
    logic [PMP_ENTRY-1:0]       match;
    logic [PMP_ENTRY-1:0][1:0]  unused_cfg_bits;
    logic [1:0]                 unused_byte_bits;

    // Checks are done on the word address of the access
    assign word             = {2'b00, acs_addr[31:2]};
    assign unused_byte_bits = acs_addr[1:0];

    for (genvar g = 0; g < PMP_ENTRY; g++) begin : g_entry
        logic [1:0]  mode;
        logic [33:0] lo;
        logic [33:0] napot_mask;

        assign mode = pmp_cfg[g][4:3];
        // Trailing ones plus the first zero bit of pmpaddr are don't-care
        assign napot_mask = pmp_addr[g] ^ (pmp_addr[g] + 34'd1);

        if (g == 0) begin : g_lo0
            assign lo = '0;
        end else begin : g_lon
            assign lo = pmp_addr[g-1];
        end

        assign match[g] =
            (mode == PMP_MODE_TOR)   ? ((word >= lo) && (word < pmp_addr[g])) :
            (mode == PMP_MODE_NA4)   ? (word == pmp_addr[g]) :
            (mode == PMP_MODE_NAPOT) ? (((word ^ pmp_addr[g]) & ~napot_mask) == 34'd0) :
                                       1'b0;

        assign unused_cfg_bits[g] = pmp_cfg[g][6:5];
    end

    // Descending scan so the lowest matching entry determines the result
    always_comb begin
        pmp_err = (privilege_mode != PRIV_M);
        for (int i = PMP_ENTRY - 1; i >= 0; i--) begin
            if (match[i]) begin
                if ((privilege_mode == PRIV_M) && !pmp_cfg[i][7]) begin
                    pmp_err = 1'b0;
                end else begin
                    pmp_err = ((acs_type & pmp_cfg[i][2:0]) == 3'b000);
                end
            end
        end
        if (!acs_en) begin
            pmp_err = 1'b0;
        end
    end

endmodule

// File: rtl/pmp_arbiter.sv
// Arbiter sharing one PMP checker between instruction fetch and load/store.
// A granted access is registered into a single check stage and answered
// one cycle later on the owner's rvalid/err.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   pmpcfg_i, pmpaddr_i      PMP configuration from the CSR block
//   cfg_busy_i               CSR update in progress, blocks new grants
//   if_*                     fetch requester (req/addr/priv in, gnt/rvalid/err out, kill in)
//   lsu_*                    load/store requester (req/we/addr/priv in, gnt/rvalid/err out)
// Build option PMP_ARB_RR_EN: round-robin arbitration replaces fixed LSU
// priority with the STARVE_MAX starvation counter.
module pmp_arbiter
    import pmp_arbiter_pkg::*;
#(
    parameter int PMP_ENTRY  = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PMP_ENTRY-1:0][7:0]  pmpcfg_i,
    input  logic [PMP_ENTRY-1:0][33:0] pmpaddr_i,
    input  logic                       cfg_busy_i,
    input  privilege_e                 if_priv_i,
    input  logic                       if_req_i,
    input  logic [31:0]                if_addr_i,
    output logic                       if_gnt_o,
    output logic                       if_rvalid_o,
    output logic                       if_err_o,
    input  logic                       if_kill_i,
    input  privilege_e                 lsu_priv_i,
    input  logic                       lsu_req_i,
    input  logic                       lsu_we_i,
    input  logic [31:0]                lsu_addr_i,
    output logic                       lsu_gnt_o,
    output logic                       lsu_rvalid_o,
    output logic                       lsu_err_o
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       if_ok;
    logic       both;
    logic       if_gnt;
    logic       lsu_gnt;
    logic       pmp_err;

    logic       stg_valid;
    pmp_req_e   stg_owner;
    logic [31:0] stg_addr;
    logic [2:0] stg_acs;
    privilege_e stg_priv;

    // A killed fetch cannot be granted; the LSU may take the slot instead
    assign if_ok = if_req_i && !if_kill_i;
    assign both  = if_ok && lsu_req_i;

`ifdef PMP_ARB_RR_EN
    pmp_req_e   rr_ptr;
    logic [3:0] unused_starve;

    assign unused_starve = STARVE_LIM;

    always_comb begin
        if_gnt  = 1'b0;
        lsu_gnt = 1'b0;
        if (!rst_i && !cfg_busy_i) begin
            if (both) begin
                if (rr_ptr == REQ_IF) if_gnt = 1'b1;
                else                  lsu_gnt = 1'b1;
            end else if (if_ok) begin
                if_gnt = 1'b1;
            end else if (lsu_req_i) begin
                lsu_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= REQ_IF;
        end else if (if_gnt) begin
            rr_ptr <= REQ_LSU;
        end else if (lsu_gnt) begin
            rr_ptr <= REQ_IF;
        end
    end
`else
    logic [3:0] starve_cnt;

    always_comb begin
        if_gnt  = 1'b0;
        lsu_gnt = 1'b0;
        if (!rst_i && !cfg_busy_i) begin
            if (both) begin
                // >= covers the count having run past the limit while IF was killed
                if (starve_cnt >= STARVE_LIM) if_gnt = 1'b1;
                else                          lsu_gnt = 1'b1;
            end else if (if_ok) begin
                if_gnt = 1'b1;
            end else if (lsu_req_i) begin
                lsu_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt || !if_req_i) begin
            starve_cnt <= 4'd0;
        end else if (lsu_gnt && (starve_cnt != 4'hF)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stg_valid <= 1'b0;
            stg_owner <= REQ_IF;
            stg_addr  <= 32'd0;
            stg_acs   <= 3'b000;
            stg_priv  <= PRIV_U;
        end else begin
            stg_valid <= if_gnt || lsu_gnt;
            if (if_gnt) begin
                stg_owner <= REQ_IF;
                stg_addr  <= if_addr_i;
                stg_acs   <= ACS_X;
                stg_priv  <= if_priv_i;
            end else if (lsu_gnt) begin
                stg_owner <= REQ_LSU;
                stg_addr  <= lsu_addr_i;
                stg_acs   <= lsu_we_i ? ACS_W : ACS_R;
                stg_priv  <= lsu_priv_i;
            end
        end
    end

    pmp_arbiter_pmp #(
        .PMP_ENTRY (PMP_ENTRY)
    ) u_pmp (
        .pmp_cfg        (pmpcfg_i),
        .pmp_addr       (pmpaddr_i),
        .acs_en         (stg_valid),
        .acs_addr       (stg_addr),
        .acs_type       (stg_acs),
        .privilege_mode (stg_priv),
        .pmp_err        (pmp_err)
    );

    logic if_rvalid;
    logic lsu_rvalid;

    // Gating with rst_i drops a check that is in the stage when reset hits
    assign if_rvalid  = !rst_i && stg_valid && (stg_owner == REQ_IF) && !if_kill_i;
    assign lsu_rvalid = !rst_i && stg_valid && (stg_owner == REQ_LSU);

    assign if_gnt_o     = if_gnt;
    assign lsu_gnt_o    = lsu_gnt;
    assign if_rvalid_o  = if_rvalid;
    assign lsu_rvalid_o = lsu_rvalid;
    assign if_err_o     = if_rvalid && pmp_err;
    assign lsu_err_o    = lsu_rvalid && pmp_err;

endmodule

// File: tb/tb_pmp_arbiter.sv
module tb_pmp_arbiter;
    import pmp_arbiter_pkg::*;

    localparam int PMP_ENTRY  = 16;
    localparam int STARVE_MAX = 3;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                       rst_i;
    logic [PMP_ENTRY-1:0][7:0]  pmpcfg;
    logic [PMP_ENTRY-1:0][33:0] pmpaddr;
    logic                       cfg_busy;
    privilege_e                 if_priv, lsu_priv;
    logic                       if_req, lsu_req, lsu_we, if_kill;
    logic [31:0]                if_addr, lsu_addr;
    logic                       if_gnt, if_rvalid, if_err;
    logic                       lsu_gnt, lsu_rvalid, lsu_err;

    pmp_arbiter #(.PMP_ENTRY(PMP_ENTRY), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pmpcfg_i     (pmpcfg),
        .pmpaddr_i    (pmpaddr),
        .cfg_busy_i   (cfg_busy),
        .if_priv_i    (if_priv),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_gnt_o     (if_gnt),
        .if_rvalid_o  (if_rvalid),
        .if_err_o     (if_err),
        .if_kill_i    (if_kill),
        .lsu_priv_i   (lsu_priv),
        .lsu_req_i    (lsu_req),
        .lsu_we_i     (lsu_we),
        .lsu_addr_i   (lsu_addr),
        .lsu_gnt_o    (lsu_gnt),
        .lsu_rvalid_o (lsu_rvalid),
        .lsu_err_o    (lsu_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_lsu_run;   // LSU grants since IF last got one / stopped asking
    bit          m_if_turn;   // round-robin: IF is next
    bit          p_valid, p_is_if;
    logic [31:0] p_addr;
    logic [2:0]  p_acs;
    privilege_e  p_priv;

    logic s_if_gnt, s_lsu_gnt, s_if_rvalid, s_if_err, s_lsu_rvalid, s_lsu_err;
    logic [7:0] seq;

    // PMP rules with byte-address ranges
    function automatic logic ref_err(input logic [31:0] a, input logic [2:0] acs,
                                     input privilege_e priv);
        longint unsigned pa, lo, hi, sz;
        int k;
        bit hit;
        pa = {32'd0, a};
        for (int i = 0; i < PMP_ENTRY; i++) begin
            hit = 0;
            lo  = 0;
            case (pmpcfg[i][4:3])
                2'd1: begin
                    if (i > 0) lo = {30'd0, pmpaddr[i-1]} << 2;
                    hi  = {30'd0, pmpaddr[i]} << 2;
                    hit = (pa >= lo) && (pa < hi);
                end
                2'd2: begin
                    lo  = {30'd0, pmpaddr[i]} << 2;
                    hit = (pa >= lo) && (pa < lo + 4);
                end
                2'd3: begin
                    k = 0;
                    while (k < 34 && pmpaddr[i][k]) k++;
                    sz  = 64'd8 << k;
                    lo  = ({30'd0, pmpaddr[i]} << 2) & ~(sz - 1);
                    hit = (pa >= lo) && (pa < lo + sz);
                end
                default: hit = 0;
            endcase
            if (hit) begin
                if (priv == PRIV_M && !pmpcfg[i][7]) return 1'b0;
                case (acs)
                    3'b100:  return !pmpcfg[i][2];
                    3'b010:  return !pmpcfg[i][1];
                    default: return !pmpcfg[i][0];
                endcase
            end
        end
        return priv != PRIV_M;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, advance the model at posedge
    task automatic cycle();
        logic can_if, can_lsu, e_if_gnt, e_lsu_gnt, e_ifv, e_ife, e_lv, e_le;
        @(negedge clk_i);
        can_if    = if_req && !if_kill && !cfg_busy && !rst_i;
        can_lsu   = lsu_req && !cfg_busy && !rst_i;
        e_if_gnt  = 1'b0;
        e_lsu_gnt = 1'b0;
        if (can_if && can_lsu) begin
`ifdef PMP_ARB_RR_EN
            if (m_if_turn) e_if_gnt = 1'b1; else e_lsu_gnt = 1'b1;
`else
            if (m_lsu_run >= STARVE_MAX) e_if_gnt = 1'b1; else e_lsu_gnt = 1'b1;
`endif
        end else begin
            e_if_gnt  = can_if;
            e_lsu_gnt = can_lsu;
        end
        e_ifv = !rst_i && p_valid && p_is_if && !if_kill;
        e_lv  = !rst_i && p_valid && !p_is_if;
        e_ife = e_ifv && ref_err(p_addr, p_acs, p_priv);
        e_le  = e_lv && ref_err(p_addr, p_acs, p_priv);

        s_if_gnt     = if_gnt;
        s_lsu_gnt    = lsu_gnt;
        s_if_rvalid  = if_rvalid;
        s_if_err     = if_err;
        s_lsu_rvalid = lsu_rvalid;
        s_lsu_err    = lsu_err;

        chk("if_gnt",     {31'd0, s_if_gnt},     {31'd0, e_if_gnt});
        chk("lsu_gnt",    {31'd0, s_lsu_gnt},    {31'd0, e_lsu_gnt});
        chk("if_rvalid",  {31'd0, s_if_rvalid},  {31'd0, e_ifv});
        chk("if_err",     {31'd0, s_if_err},     {31'd0, e_ife});
        chk("lsu_rvalid", {31'd0, s_lsu_rvalid}, {31'd0, e_lv});
        chk("lsu_err",    {31'd0, s_lsu_err},    {31'd0, e_le});

        @(posedge clk_i);
        if (rst_i) begin
            m_lsu_run = 0;
            m_if_turn = 1;
            p_valid   = 0;
        end else begin
            if (!if_req || e_if_gnt) m_lsu_run = 0;
            else if (e_lsu_gnt)      m_lsu_run++;
            if (e_if_gnt)       m_if_turn = 0;
            else if (e_lsu_gnt) m_if_turn = 1;
            p_valid = e_if_gnt || e_lsu_gnt;
            p_is_if = e_if_gnt;
            p_addr  = e_if_gnt ? if_addr : lsu_addr;
            p_acs   = e_if_gnt ? 3'b100 : (lsu_we ? 3'b010 : 3'b001);
            p_priv  = e_if_gnt ? if_priv : lsu_priv;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] b;
        case ($urandom_range(0, 5))
            0: b = 32'h8000_0000;
            1: b = 32'h2000_0000;
            2: b = 32'h3000_0000;
            3: b = 32'h3800_0000;
            4: b = 32'h5000_0000;
            default: return $urandom;
        endcase
        return b + 32'($urandom_range(0, 8191));
    endfunction

    function automatic privilege_e rand_priv();
        case ($urandom_range(0, 2))
            0: return PRIV_U;
            1: return PRIV_S;
            default: return PRIV_M;
        endcase
    endfunction

    initial begin
        pmpcfg  = '0;
        pmpaddr = '0;
        pmpcfg[0] = 8'h1C; pmpaddr[0] = 34'h0_2000_1FFF; // NAPOT 64K @8000_0000, X
        pmpcfg[1] = 8'h19; pmpaddr[1] = 34'h0_0800_01FF; // NAPOT 4K  @2000_0000, R
        pmpcfg[2] = 8'h13; pmpaddr[2] = 34'h0_0C00_0000; // NA4 @3000_0000, RW
        pmpcfg[3] = 8'h0F; pmpaddr[3] = 34'h0_1000_0000; // TOR 3000_0000..4000_0000, RWX
        pmpcfg[4] = 8'h98; pmpaddr[4] = 34'h0_1400_01FF; // locked NAPOT 4K @5000_0000, none

        rst_i = 1; cfg_busy = 0; if_kill = 0;
        if_req = 0; if_addr = 0; if_priv = PRIV_U;
        lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_priv = PRIV_U;
        m_lsu_run = 0; m_if_turn = 1; p_valid = 0; p_is_if = 0;
        p_addr = 0; p_acs = 0; p_priv = PRIV_U;
        @(posedge clk_i); #1;

        // Reset holds grants low even with both requesting
        if_req = 1; if_addr = 32'h8000_0000;
        lsu_req = 1; lsu_addr = 32'h3000_0100; lsu_we = 0;
        cycle();
        chk("rst_if_gnt",  {31'd0, s_if_gnt},  32'd0);
        chk("rst_lsu_gnt", {31'd0, s_lsu_gnt}, 32'd0);
        rst_i = 0;

        // Continuous contention: grant order
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            seq[i] = s_if_gnt;
        end
`ifdef PMP_ARB_RR_EN
        chk("order_rr", {24'd0, seq}, 32'h55);
`else
        chk("order_starve", {24'd0, seq}, 32'h88);
`endif
        if_req = 0; lsu_req = 0;
        cycle();

        // Lone IF fetch, X-only NAPOT region
        if_req = 1; if_addr = 32'h8000_0000; if_priv = PRIV_U;
        cycle();
        chk("s1_gnt", {31'd0, s_if_gnt}, 32'd1);
        if_req = 0;
        cycle();
        chk("s1_rvalid", {31'd0, s_if_rvalid}, 32'd1);
        chk("s1_err",    {31'd0, s_if_err},    32'd0);

        // U-mode store to read-only region
        lsu_req = 1; lsu_we = 1; lsu_addr = 32'h2000_0010; lsu_priv = PRIV_U;
        cycle();
        chk("s2_gnt", {31'd0, s_lsu_gnt}, 32'd1);
        lsu_req = 0;
        cycle();
        chk("s2_rvalid", {31'd0, s_lsu_rvalid}, 32'd1);
        chk("s2_err",    {31'd0, s_lsu_err},    32'd1);

        // cfg_busy for two cycles with an access in flight
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h3000_0000; lsu_priv = PRIV_S;
        cycle();
        if_req = 1; if_addr = 32'h8000_0004; if_priv = PRIV_S; cfg_busy = 1;
        cycle();
        chk("s4_gnt_b0",  {30'd0, s_if_gnt, s_lsu_gnt}, 32'd0);
        chk("s4_inflight", {31'd0, s_lsu_rvalid},       32'd1);
        cycle();
        chk("s4_gnt_b1", {30'd0, s_if_gnt, s_lsu_gnt}, 32'd0);
        cfg_busy = 0;
        cycle();
        chk("s4_resume", {31'd0, s_if_gnt | s_lsu_gnt}, 32'd1);
        if (s_if_gnt)  if_req = 0;
        if (s_lsu_gnt) lsu_req = 0;
        cycle();
        if_req = 0; lsu_req = 0;
        cycle();
        cycle();

        // Kill the IF result while the LSU takes the slot
        if_req = 1; if_addr = 32'h8000_0000; if_priv = PRIV_M;
        cycle();
        chk("s5_if_gnt", {31'd0, s_if_gnt}, 32'd1);
        if_req = 0; if_kill = 1;
        lsu_req = 1; lsu_addr = 32'h3800_0000; lsu_we = 1; lsu_priv = PRIV_U;
        cycle();
        chk("s5_killed",  {31'd0, s_if_rvalid}, 32'd0);
        chk("s5_lsu_gnt", {31'd0, s_lsu_gnt},   32'd1);
        if_kill = 0; lsu_req = 0;
        cycle();
        chk("s5_lsu_rvalid", {31'd0, s_lsu_rvalid}, 32'd1);
        chk("s5_lsu_err",    {31'd0, s_lsu_err},    32'd0);

        // Locked entry faults even in M-mode
        lsu_req = 1; lsu_addr = 32'h5000_0040; lsu_we = 0; lsu_priv = PRIV_M;
        cycle();
        lsu_req = 0;
        cycle();
        chk("lock_err", {31'd0, s_lsu_err}, 32'd1);

        // Reset right after a grant drops the access
        if_req = 1; if_addr = 32'h8000_0000; if_priv = PRIV_U;
        cycle();
        chk("s6_gnt", {31'd0, s_if_gnt}, 32'd1);
        if_req = 0; rst_i = 1;
        cycle();
        chk("s6_outs", {26'd0, s_if_gnt, s_if_rvalid, s_if_err,
                        s_lsu_gnt, s_lsu_rvalid, s_lsu_err}, 32'd0);
        rst_i = 0;
        cycle();
        chk("s6_dropped", {31'd0, s_if_rvalid}, 32'd0);
        if_req = 1;
        cycle();
        chk("s6_gnt2", {31'd0, s_if_gnt}, 32'd1);
        if_req = 0;
        cycle();
        chk("s6_rvalid2", {31'd0, s_if_rvalid}, 32'd1);
        chk("s6_err2",    {31'd0, s_if_err},    32'd0);

        // Randomized traffic with handshake-respecting requesters
        for (int n = 0; n < 400; n++) begin
            if (!if_req || s_if_gnt) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = rand_addr();
                if_priv = rand_priv();
            end
            if (!lsu_req || s_lsu_gnt) begin
                lsu_req  = ($urandom_range(0, 3) != 0);
                lsu_addr = rand_addr();
                lsu_priv = rand_priv();
                lsu_we   = 1'($urandom_range(0, 1));
            end
            if_kill  = ($urandom_range(0, 9) == 0);
            cfg_busy = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pmp_arbiter.md
Name: pmp_arbiter

Overview:
Shares one pmp checker instance between the instruction-fetch (IF) and load/store (LSU) requesters.
- Arbitrates the requests and registers the granted access into a single check stage.
- Returns a per-requester rvalid/err response one cycle after grant, at a throughput of one check per cycle.
- Sits between the IF/LSU front ends and the PMP CSR block, which supplies pmpcfg/pmpaddr.

Parameters:
PMP_ENTRY, 16, number of PMP entries; passed to the internal pmp instance.
STARVE_MAX, 3, maximum consecutive LSU grants while IF is requesting before IF is forced a grant; legal range 1..15.

Ports:
clk_i  in  1  clock; all logic on its rising edge.
rst_i  in  1  synchronous, active-high reset.
pmpcfg_i  in  [PMP_ENTRY-1:0][7:0]  per-entry PMP config (L, A, X/W/R), from the CSR block.
pmpaddr_i  in  [PMP_ENTRY-1:0][33:0]  per-entry PMP address.
cfg_busy_i  in  1  CSR write to pmpcfg/pmpaddr in progress; blocks new grants.
if_priv_i  in  privilege_e  effective privilege for fetch.
if_req_i  in  1  IF check request.
if_addr_i  in  32  IF address.
if_gnt_o  out  1  IF request accepted this cycle.
if_rvalid_o  out  1  IF result valid.
if_err_o  out  1  IF access fault; meaningful only with if_rvalid_o.
if_kill_i  in  1  discard any IF result in flight (pipeline flush).
lsu_priv_i  in  privilege_e  effective data privilege (MPRV already applied).
lsu_req_i  in  1  LSU check request.
lsu_we_i  in  1  1 = store (W), 0 = load (R).
lsu_addr_i  in  32  LSU address.
lsu_gnt_o  out  1  LSU request accepted.
lsu_rvalid_o  out  1  LSU result valid.
lsu_err_o  out  1  LSU access fault; meaningful only with lsu_rvalid_o.

Behaviour:
- Clocking and reset: single clock clk_i; reset rst_i is synchronous, active-high.
- Reset values:
  - all *_gnt_o, *_rvalid_o and *_err_o are 0;
  - stage valid is 0;
  - starvation counter is 0;
  - round-robin pointer is IF.
- Reset while a check is in flight drops it; no rvalid is produced for it.
- Requester handshake:
  - A requester holds req and all its attributes stable until gnt.
  - gnt is combinational from req, cfg_busy_i and arbiter state.
  - At most one gnt is asserted per cycle.
- No grant while cfg_busy_i=1. A check already in the stage completes against the current cfg.
- Grant selection (default build):
  - LSU has priority.
  - The counter increments on each LSU grant while if_req_i=1, and clears on any IF grant or when if_req_i=0.
  - When the counter equals STARVE_MAX and both requests are present, IF is granted.
  - Only one requester active: that requester is granted.
- Check stage:
  - On gnt, register {owner, addr, acs_type, priv} and set valid=1 next cycle; otherwise valid=0.
  - acs_type is one-hot [X,W,R]: IF gives 3'b100; LSU gives 3'b010 when lsu_we_i=1, 3'b001 when lsu_we_i=0.
- Check and response (cycle N+1 after a grant in cycle N):
  - The pmp instance is driven from the stage registers: acs_en = valid, privilege_mode = registered priv.
  - The owner's rvalid_o=1 and err_o = pmp_err_o, both combinational from the stage.
  - The non-owner's rvalid_o and err_o are 0.
  - Latency is exactly 1 cycle from gnt to rvalid.
- Back-to-back grants in consecutive cycles are legal.
- if_kill_i:
  - If the stage owner is IF, if_rvalid_o is forced 0 that cycle.
  - if_kill_i=1 also blocks an IF grant in the same cycle.
  - LSU is unaffected.
- Simultaneous events:
  - if_kill_i together with an LSU grant: the LSU grant proceeds.
  - cfg_busy_i together with both requests: neither is granted; the counter holds.

Optional Feature:
PMP_ARB_RR_EN defined:
- The starvation counter is removed and a 1-bit round-robin pointer is used.
- With both requests present, grant the requester named by the pointer; the pointer then flips to the other requester.
- With one request present, grant it and set the pointer to the other requester.
Undefined: fixed LSU priority with the STARVE_MAX counter, as in Behaviour.

Decomposition:
Shared package (existing, alongside privilege_e and the PMP mode constants) gains:
- ACS_R=3'b001, ACS_W=3'b010, ACS_X=3'b100;
- enum pmp_req_e {REQ_IF, REQ_LSU}.

One sub-module: the existing pmp checker, instantiated once. The arbitration select logic stays inline.

Test Plan:
1. Lone IF req, addr 0x8000_0000, NAPOT entry RWX=3'b100 -> if_gnt_o=1 in cycle 0; if_rvalid_o=1, if_err_o=0 in cycle 1.
2. LSU store to 0x2000_0010, U-mode, entry R-only -> lsu_rvalid_o=1, lsu_err_o=1 one cycle after gnt.
3. IF and LSU requesting continuously, STARVE_MAX=3 -> grant order LSU,LSU,LSU,IF repeating; under PMP_ARB_RR_EN the order is IF,LSU,IF,LSU.
4. cfg_busy_i=1 for 2 cycles with both requesting -> no gnt during those 2 cycles; an in-flight result still returns; granting resumes the cycle cfg_busy_i falls.
5. IF granted, if_kill_i=1 in the next cycle -> if_rvalid_o stays 0; an LSU gnt in that same cycle returns lsu_rvalid_o=1 in the following cycle.
6. rst_i asserted in the cycle after a grant -> no rvalid, all outputs 0, counter 0; the first post-reset grant behaves as in scenario 1.
